text_memory_arbiter: RTL

//  Shares one pipelined read-only text memory bus between two requesters:

---
 rtl/text_memory_arbiter_if.sv | 25 ++
 rtl/text_memory_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/text_memory_arbiter_if.sv
// Pipelined read-only bus: a request with a stall back-channel and an
// in-order response strobe. The master drives the request side.
interface text_memory_arbiter_if;
   logic        read_enable;
   logic [31:0] address;
   logic        wait_req;
   logic [31:0] read_data;
   logic        valid;

   modport master (
      output read_enable,
      output address,
      input  wait_req,
      input  read_data,
      input  valid
   );

   modport slave (
      input  read_enable,
      input  address,
      output wait_req,
      output read_data,
      output valid
   );
endinterface

// File: rtl/text_memory_arbiter.sv
// Two-port round-robin arbiter in front of a pipelined text memory.
// Port 0 is the icache refill path, port 1 a secondary reader. A stalled
// request keeps its grant so the memory sees a stable address, and the IDs
// of issued reads travel through a small FIFO so that in-order responses
// can be steered back to the port that asked for them.
module text_memory_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   text_memory_arbiter_if.slave         p0,
   text_memory_arbiter_if.slave         p1,
   text_memory_arbiter_if.master        ram,
   output logic                         err_orphan_valid
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

   logic [MAX_OUTSTANDING-1:0] id_fifo;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [CW-1:0]              outstanding;
   logic                       lock;
   logic                       locked_id;
   logic                       last_grant;

   logic                       grant_valid;
   logic                       grant_id;
   logic                       grant_read_enable;
   logic                       full;
   logic                       issue;
   logic                       transfer;
   logic                       pop;
   logic                       head_id;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
   endfunction

   // Pick the port that owns the memory bus this cycle; a stalled request keeps it.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (reset) begin
         grant_valid = 1'b0;
      end else if (lock) begin
         grant_valid = 1'b1;
         grant_id    = locked_id;
      end else if (p0.read_enable && p1.read_enable) begin
         grant_valid = 1'b1;
         grant_id    = ~last_grant;
      end else if (p0.read_enable) begin
         grant_valid = 1'b1;
      end else if (p1.read_enable) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end
   end

   // Drive the memory request, the per-port stalls and the response steering.
   always_comb begin
      full              = (outstanding == MAX_COUNT);
      grant_read_enable = grant_id ? p1.read_enable : p0.read_enable;
      issue             = grant_valid && grant_read_enable && !full;
      transfer          = issue && !ram.wait_req;
      pop               = ram.valid && (outstanding != '0);
      head_id           = id_fifo[rd_ptr];

      ram.read_enable   = issue;
      ram.address       = grant_valid ? (grant_id ? p1.address : p0.address) : 32'h0;

      p0.wait_req       = p0.read_enable &&
                          !(grant_valid && !grant_id && !ram.wait_req && !full);
      p1.wait_req       = p1.read_enable &&
                          !(grant_valid && grant_id && !ram.wait_req && !full);

      p0.valid          = pop && !head_id;
      p1.valid          = pop && head_id;
      p0.read_data      = ram.read_data;
      p1.read_data      = ram.read_data;
   end

   // Track issued read IDs in order and count reads still waiting for data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_fifo     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         if (transfer) begin
            id_fifo[wr_ptr] <= grant_id;
            wr_ptr          <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({transfer, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Hold the grant across memory stalls and remember who won last for fairness.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock       <= 1'b0;
         locked_id  <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (transfer) begin
            lock       <= 1'b0;
            last_grant <= grant_id;
         end else if (issue && ram.wait_req) begin
            lock      <= 1'b1;
            locked_id <= grant_id;
         end
      end
   end

   // Flag a response that arrives with no read outstanding; sticky until reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_orphan_valid <= 1'b0;
      end else if (ram.valid && (outstanding == '0)) begin
         err_orphan_valid <= 1'b1;
      end
   end

endmodule
